// File: rtl/apb_mst_pkg.sv
// Shared types and field positions for the FIFO-driven APB master.
// Command word is {write, addr, wdata}; response word is {slverr, rdata}.
package apb_mst_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    localparam int unsigned CmdDataLsb = 0;
    localparam int unsigned RspDataLsb = 0;

    function automatic int unsigned cmd_wr_pos(input int unsigned addr_w,
                                               input int unsigned data_w);
        return addr_w + data_w;
    endfunction

    function automatic int unsigned cmd_addr_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned rsp_err_pos(input int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/apb_mst_tmo.sv
// ACCESS-phase watchdog for apb_fifo_master; only built with APB_MST_TIMEOUT_EN.
// expired rises in the TIMEOUT_CYC-th consecutive cycle that run is held.
module apb_mst_tmo #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    logic [CntW-1:0] cnt_q;

    // Count starts at 0 in the first ACCESS cycle, so the limit is TIMEOUT_CYC-1.
    assign expired = run && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/apb_fifo_master.sv
// APB master that drains a command FIFO and fills a response FIFO, one transfer at a time.
// Optional ACCESS timeout is enabled by defining APB_MST_TIMEOUT_EN.
module apb_fifo_master
    import apb_mst_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_empty_i,
    input  logic [ADDR_W+DATA_W:0]   cmd_data_i,
    output logic                     cmd_pop_o,
    input  logic                     rsp_full_i,
    output logic                     rsp_push_o,
    output logic [DATA_W:0]          rsp_data_o,
    output logic                     psel_o,
    output logic                     penable_o,
    output logic                     pwrite_o,
    output logic [ADDR_W-1:0]        paddr_o,
    output logic [DATA_W-1:0]        pwdata_o,
    input  logic [DATA_W-1:0]        prdata_i,
    input  logic                     pready_i,
    input  logic                     pslverr_i,
    output logic                     busy_o
);

    localparam int unsigned CmdWrPos  = cmd_wr_pos(ADDR_W, DATA_W);
    localparam int unsigned AddrLsb   = cmd_addr_lsb(DATA_W);
    localparam int unsigned RspErrPos = rsp_err_pos(DATA_W);

    state_e              state_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [DATA_W:0]     rsp_q;

    logic cmd_pop;
    logic rsp_push;
    logic tmo_expired;

    assign rsp_push = (state_q == StResp) && !rsp_full_i;
    // Pop from IDLE, or from RESP in the same cycle the response leaves; reset blocks it.
    assign cmd_pop  = reset && !cmd_empty_i &&
                      ((state_q == StIdle) || ((state_q == StResp) && !rsp_full_i));

`ifdef APB_MST_TIMEOUT_EN
    apb_mst_tmo #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (cmd_pop),
        .run     (state_q == StAccess),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rsp_q     <= '0;
        end else begin
            case (state_q)
                StIdle, StResp: begin
                    if (cmd_pop) begin
                        state_q   <= StSetup;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= cmd_data_i[CmdWrPos];
                        paddr_q   <= cmd_data_i[AddrLsb +: ADDR_W];
                        pwdata_q  <= cmd_data_i[CmdDataLsb +: DATA_W];
                    end else if (rsp_push) begin
                        state_q <= StIdle;
                    end
                end
                StSetup: begin
                    state_q   <= StAccess;
                    penable_q <= 1'b1;
                end
                StAccess: begin
                    if (pready_i) begin
                        state_q                         <= StResp;
                        psel_q                          <= 1'b0;
                        penable_q                       <= 1'b0;
                        rsp_q[RspErrPos]                <= pslverr_i;
                        rsp_q[RspDataLsb +: DATA_W]     <= pwrite_q ? '0 : prdata_i;
                    end else if (tmo_expired) begin
                        state_q                         <= StResp;
                        psel_q                          <= 1'b0;
                        penable_q                       <= 1'b0;
                        rsp_q[RspErrPos]                <= 1'b1;
                        rsp_q[RspDataLsb +: DATA_W]     <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_pop_o  = cmd_pop;
    assign rsp_push_o = rsp_push;
    assign rsp_data_o = rsp_q;
    assign psel_o     = psel_q;
    assign penable_o  = penable_q;
    assign pwrite_o   = pwrite_q;
    assign paddr_o    = paddr_q;
    assign pwdata_o   = pwdata_q;
    assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_apb_fifo_master.sv
// Bench for apb_fifo_master: modelled command/response FIFOs, an APB slave driven from a
// command table, and a response scoreboard. Define APB_MST_TIMEOUT_EN to add the timeout case.
module tb_apb_fifo_master;

    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_empty_i;
    logic [AW+DW:0]  cmd_data_i;
    logic            cmd_pop_o;
    logic            rsp_full_i;
    logic            rsp_push_o;
    logic [DW:0]     rsp_data_o;
    logic            psel_o, penable_o, pwrite_o;
    logic [AW-1:0]   paddr_o;
    logic [DW-1:0]   pwdata_o;
    logic [DW-1:0]   prdata_i;
    logic            pready_i, pslverr_i;
    logic            busy_o;

    always #5 clk = ~clk;

    apb_fifo_master #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_empty_i (cmd_empty_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_pop_o   (cmd_pop_o),
        .rsp_full_i  (rsp_full_i),
        .rsp_push_o  (rsp_push_o),
        .rsp_data_o  (rsp_data_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i),
        .busy_o      (busy_o)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;     // ACCESS cycles with pready low before completion
        logic [DW-1:0] prdata;
        logic          slverr;
        int            full_cyc;  // RESP cycles with the response FIFO full
        bit            tmo;       // slave never answers
        int            grp;       // commands of one group are queued together
        int            pop_cyc;
    } cmd_t;

    cmd_t        vecs[$];
    cmd_t        fifo_q[$];
    cmd_t        inflight_q[$];
    logic [DW:0] sb_q[$];

    cmd_t cur;
    bit   have_cur    = 1'b0;
    bit   pending_pop = 1'b0;
    int   acc_cnt     = 0;
    int   full_left   = 0;
    int   cycle       = 0;
    int   n_pass      = 0;
    int   n_checks    = 0;

    function automatic cmd_t mk(input logic wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input int waits,
                                input logic [DW-1:0] prdata, input logic slverr,
                                input int full_cyc, input bit tmo, input int grp);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wdata; c.waits = waits;
        c.prdata = prdata; c.slverr = slverr; c.full_cyc = full_cyc;
        c.tmo = tmo; c.grp = grp; c.pop_cyc = 0;
        return c;
    endfunction

    function automatic logic [DW:0] exp_rsp(input cmd_t c);
        if (c.tmo) return {1'b1, {DW{1'b0}}};
        return {c.slverr, c.wr ? {DW{1'b0}} : c.prdata};
    endfunction

    function automatic int exp_acc(input cmd_t c);
        return c.tmo ? int'(TMO) : c.waits + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic enqueue(input cmd_t c);
        fifo_q.push_back(c);
        sb_q.push_back(exp_rsp(c));
    endtask

    // One clock: drive inputs on the falling edge, then check outputs 1 time unit later.
    task automatic step();
        cmd_t        h;
        logic [63:0] r;
        logic [DW:0] e;
        bit          resp_state;
        @(negedge clk);
        cycle++;
        if (pending_pop) begin
            h = fifo_q.pop_front();
            h.pop_cyc = cycle - 1;
            inflight_q.push_back(h);
            pending_pop = 1'b0;
        end
        if (psel_o && !penable_o) begin
            if (inflight_q.size() == 0) begin
                check("spurious_setup", psel_o, 1'b0);
            end else begin
                cur = inflight_q.pop_front();
                have_cur = 1'b1;
                acc_cnt = 0;
                full_left = cur.full_cyc;
                check("setup_cycle", cycle, cur.pop_cyc + 1);
                check("setup_paddr", paddr_o, cur.addr);
                check("setup_pwrite", pwrite_o, cur.wr);
                if (cur.wr) check("setup_pwdata", pwdata_o, cur.wdata);
            end
            pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom;
        end else if (psel_o && penable_o && have_cur) begin
            acc_cnt++;
            check("access_paddr_stable", paddr_o, cur.addr);
            if (cur.wr) check("access_pwdata_stable", pwdata_o, cur.wdata);
            if (!cur.tmo && acc_cnt > cur.waits) begin
                pready_i = 1'b1; prdata_i = cur.prdata; pslverr_i = cur.slverr;
            end else begin
                pready_i = 1'b0; prdata_i = $urandom; pslverr_i = 1'($urandom_range(0, 1));
            end
        end else begin
            pready_i = 1'($urandom_range(0, 1)); prdata_i = $urandom; pslverr_i = 1'b0;
        end
        resp_state = busy_o && !psel_o;
        if (resp_state) begin
            rsp_full_i = (full_left > 0);
            if (full_left > 0) full_left--;
        end else begin
            rsp_full_i = 1'($urandom_range(0, 1));
        end
        cmd_empty_i = (fifo_q.size() == 0);
        r = {$urandom, $urandom};
        cmd_data_i = cmd_empty_i ? r[AW+DW:0] : {fifo_q[0].wr, fifo_q[0].addr, fifo_q[0].wdata};
        #1;
        if (cmd_pop_o) begin
            if (cmd_empty_i) check("pop_when_empty", cmd_pop_o, 1'b0);
            else pending_pop = 1'b1;
        end
        if (resp_state && rsp_full_i) begin
            check("bp_no_push", rsp_push_o, 1'b0);
            check("bp_no_pop", cmd_pop_o, 1'b0);
            if (sb_q.size() > 0) check("bp_rsp_hold", rsp_data_o, sb_q[0]);
        end else if (rsp_push_o) begin
            if (sb_q.size() == 0 || !have_cur) begin
                check("spurious_push", rsp_push_o, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_data", rsp_data_o, e);
                check("access_cycles", acc_cnt, exp_acc(cur));
                check("push_latency", cycle - cur.pop_cyc, 2 + exp_acc(cur) + cur.full_cyc);
                have_cur = 1'b0;
            end
        end
    endtask

    task automatic drain(input string name);
        int budget = 0;
        while (sb_q.size() > 0 && budget < 300) begin
            step();
            budget++;
        end
        check(name, sb_q.size(), 0);
        repeat (3) step();
        check("idle_after_drain", busy_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngrp = 0;
        int budget;

        vecs.push_back(mk(1'b1, 8'h10, 32'hDEADBEEF, 0, 32'hCAFEF00D, 1'b0, 0, 1'b0, 0));
        vecs.push_back(mk(1'b0, 8'h24, 32'h0,        3, 32'h12345678, 1'b0, 0, 1'b0, 1));
        vecs.push_back(mk(1'b0, 8'h38, 32'h0,        0, 32'hA5A50001, 1'b0, 5, 1'b0, 2));
        vecs.push_back(mk(1'b1, 8'h40, 32'h11112222, 1, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 3));
        vecs.push_back(mk(1'b0, 8'h44, 32'h0,        0, 32'h0BADF00D, 1'b1, 0, 1'b0, 3));
        vecs.push_back(mk(1'b1, 8'h48, 32'h33334444, 2, 32'h55555555, 1'b0, 2, 1'b0, 3));
        vecs.push_back(mk(1'b0, 8'hFF, 32'h0,        0, 32'h80000001, 1'b0, 1, 1'b0, 4));
`ifdef APB_MST_TIMEOUT_EN
        vecs.push_back(mk(1'b0, 8'h50, 32'h0,        0, 32'h77777777, 1'b0, 0, 1'b1, 5));
`endif
        foreach (vecs[i]) if (vecs[i].grp + 1 > ngrp) ngrp = vecs[i].grp + 1;

        // Reset with a non-empty command FIFO: nothing may pop or push.
        reset = 1'b0; cmd_empty_i = 1'b0; cmd_data_i = {1'b1, 8'hAB, 32'h01234567};
        rsp_full_i = 1'b0; pready_i = 1'b1; pslverr_i = 1'b0; prdata_i = 32'hFFFF0000;
        repeat (3) @(negedge clk);
        #1;
        check("rst_psel", psel_o, 1'b0);
        check("rst_penable", penable_o, 1'b0);
        check("rst_pwrite", pwrite_o, 1'b0);
        check("rst_cmd_pop", cmd_pop_o, 1'b0);
        check("rst_rsp_push", rsp_push_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_paddr", paddr_o, 0);
        check("rst_pwdata", pwdata_o, 0);
        check("rst_rsp_data", rsp_data_o, 0);
        @(negedge clk);
        reset = 1'b1; cmd_empty_i = 1'b1;
        repeat (3) step();
        check("idle_no_pop", cmd_pop_o, 1'b0);

        for (int g = 0; g < ngrp; g++) begin
            foreach (vecs[i]) if (vecs[i].grp == g) enqueue(vecs[i]);
            drain("group_drain");
        end

        // Reset during a long ACCESS aborts it with no response.
        enqueue(mk(1'b0, 8'h60, 32'h0, 50, 32'h99999999, 1'b0, 0, 1'b0, 9));
        budget = 0;
        while (!(psel_o && penable_o) && budget < 20) begin
            step();
            budget++;
        end
        check("abort_reached_access", penable_o, 1'b1);
        repeat (2) step();
        @(negedge clk);
        cycle++;
        reset = 1'b0;
        #1;
        check("abort_psel", psel_o, 1'b0);
        check("abort_penable", penable_o, 1'b0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_push", rsp_push_o, 1'b0);
        @(negedge clk);
        cycle++;
        reset = 1'b1;
        void'(sb_q.pop_back());
        inflight_q.delete();
        have_cur = 1'b0;
        pending_pop = 1'b0;
        repeat (6) step();
        check("abort_idle", busy_o, 1'b0);

        enqueue(mk(1'b1, 8'h70, 32'hFEEDFACE, 1, 32'h0, 1'b0, 0, 1'b0, 10));
        enqueue(mk(1'b0, 8'h74, 32'h0, 0, 32'h13572468, 1'b0, 1, 1'b0, 10));
        drain("recovery_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_fifo_master.md
APB_FIFO_MASTER -- requirements
Module: apb_fifo_master

Interface
REQ-001 Parameter ADDR_W, default 8, APB address width.
REQ-002 Parameter DATA_W, default 32, APB data width.
REQ-003 Parameter TIMEOUT_CYC, default 16, maximum ACCESS cycles before abort (used only with the timeout feature).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low (asserted at 0) reset.
REQ-006 cmd_empty_i  in  1  command FIFO empty flag.
REQ-007 cmd_data_i  in  1+ADDR_W+DATA_W  command FIFO head word {write, addr, wdata}, valid while cmd_empty_i=0.
REQ-008 cmd_pop_o  out  1  command FIFO pop strobe.
REQ-009 rsp_full_i  in  1  response FIFO full flag.
REQ-010 rsp_push_o  out  1  response FIFO push strobe.
REQ-011 rsp_data_o  out  1+DATA_W  response word {slverr, rdata}.
REQ-012 psel_o, penable_o, pwrite_o  out  1 each  APB control signals.
REQ-013 paddr_o  out  ADDR_W  APB address.
REQ-014 pwdata_o  out  DATA_W  APB write data.
REQ-015 prdata_i  in  DATA_W  APB read data.
REQ-016 pready_i, pslverr_i  in  1 each  APB completion and error.
REQ-017 busy_o  out  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS, RESP.
REQ-019 IDLE: if cmd_empty_i=0, assert cmd_pop_o for one cycle, register cmd_data_i, go to SETUP; else stay.
REQ-020 SETUP: psel_o=1, penable_o=0, paddr_o/pwrite_o/pwdata_o from the registered command; go to ACCESS after one cycle.
REQ-021 ACCESS: psel_o=1, penable_o=1; stay while pready_i=0; on pready_i=1, register {pslverr_i, prdata_i} and go to RESP.
REQ-022 Response data for a write command: rdata field=0, slverr=pslverr_i.
REQ-023 RESP: psel_o=0; rsp_push_o=1 only when rsp_full_i=0; hold rsp_data_o stable while rsp_full_i=1.
REQ-024 RESP with push and cmd_empty_i=0: pop the next command in the same cycle and go directly to SETUP.
REQ-025 RESP with push and cmd_empty_i=1: go to IDLE.
REQ-026 cmd_pop_o shall never assert while cmd_empty_i=1; rsp_push_o shall never assert while rsp_full_i=1.
REQ-027 Exactly one response is pushed per popped command, in command order.
REQ-028 paddr_o, pwrite_o and pwdata_o are stable from SETUP through the end of ACCESS.
REQ-029 Latency: command present in IDLE cycle N; SETUP in N+1; ACCESS in N+2; with pready_i=1 at N+2 and rsp_full_i=0, rsp_push_o=1 at N+3.

Reset
REQ-030 While reset=0: state=IDLE; psel_o, penable_o, pwrite_o, cmd_pop_o, rsp_push_o and busy_o are 0; paddr_o, pwdata_o and rsp_data_o are 0.
REQ-031 Reset asserted mid-transfer aborts the transfer immediately; no response is pushed for the aborted command.

Configuration
REQ-032 Macro APB_MST_TIMEOUT_EN defined: a counter runs in ACCESS; at TIMEOUT_CYC cycles without pready_i, register response {1, 0} and go to RESP.
REQ-033 With APB_MST_TIMEOUT_EN defined, the counter clears on entry to SETUP.
REQ-034 APB_MST_TIMEOUT_EN undefined: ACCESS waits indefinitely; the counter logic is absent.

Structure
REQ-035 Package apb_mst_pkg holds the FSM state enum, the command field bit positions (CMD_WR bit, address slice, data slice) and the response field positions.
REQ-036 One sub-module, apb_mst_tmo, implements the timeout counter and is instantiated only when APB_MST_TIMEOUT_EN is defined.

Verification
REQ-037 Write: cmd {1, 0x10, 0xDEADBEEF}, pready_i=1 on first ACCESS -> pwrite_o=1, paddr_o=0x10, pwdata_o=0xDEADBEEF; response {0, 0x0} pushed at N+3.
REQ-038 Read with wait states: cmd {0, 0x24, x}, pready_i low 3 cycles, prdata_i=0x12345678 -> ACCESS lasts 4 cycles; response {0, 0x12345678}.
REQ-039 Backpressure: rsp_full_i=1 for 5 cycles in RESP -> no push, rsp_data_o held, no pop of the next command; push occurs the cycle rsp_full_i=0.
REQ-040 Back-to-back: 3 queued commands -> pop asserted in the RESP cycles, SETUP follows RESP directly; 3 responses in order.
REQ-041 Error/timeout: pslverr_i=1 with pready_i=1 -> response {1, prdata}; with APB_MST_TIMEOUT_EN and TIMEOUT_CYC=16, pready_i held 0 -> response {1, 0} after 16 ACCESS cycles.
REQ-042 Reset in ACCESS: reset=0 for 1 cycle -> psel_o=0 immediately, state IDLE, no rsp_push_o.
